// File: rtl/hold_seq_n_if.sv
// rtl/hold_seq_n_if.sv - control/status bundle for the hold/toggle sequencer
//
// Signals:
//   start    start request (master -> slave)
//   run_len  RUN length in cycles, captured with start (master -> slave)
//   abort    end the current RUN early (master -> slave)
//   reps     extra passes, captured with start (master -> slave)
//   g        hold output (slave -> master)
//   f        toggle output, inverts on each LAST entry (slave -> master)
//   busy     sequencer not idle (slave -> master)
//   done     final LAST cycle (slave -> master)
//   cnt      cycles spent in RUN in the current pass (slave -> master)

interface hold_seq_n_if #(
    parameter int CNT_W = 8,
    parameter int REP_W = 4
);
    logic             start;
    logic [CNT_W-1:0] run_len;
    logic             abort;
    logic [REP_W-1:0] reps;
    logic             g;
    logic             f;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] cnt;

    modport master (
        output start, run_len, abort, reps,
        input  g, f, busy, done, cnt
    );

    modport slave (
        input  start, run_len, abort, reps,
        output g, f, busy, done, cnt
    );
endinterface

// File: rtl/hold_seq_n.sv
// rtl/hold_seq_n.sv - parametrised hold/toggle sequencer (IDLE -> RUN -> LAST)
//
// Ports:
//   clk    clock, all state changes on posedge
//   rst_n  asynchronous active-low reset
//   bus    hold_seq_n_if.slave: start/run_len/abort/reps in, g/f/busy/done/cnt out
//
// Optional feature: define HOLD_SEQ_REPEAT_EN to run reps extra passes per start;
// without it reps is ignored and LAST always returns to IDLE.
//
// Every output is a register loaded from the next-state decode, so all outputs
// change on the same edge as the state.

module hold_seq_n #(
    parameter int CNT_W = 8,
    parameter int REP_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    hold_seq_n_if.slave bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_LAST = 2'd2;

    logic [1:0]       state;
    logic [1:0]       nstate;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_n;
    logic             g_q;
    logic             f_q;
    logic             busy_q;
    logic             done_q;
    logic             done_n;
    logic             accept;

    assign accept = (state == S_IDLE) && bus.start;

`ifdef HOLD_SEQ_REPEAT_EN
    logic [REP_W-1:0] rep_q;
    logic [REP_W-1:0] rep_n;
`else
    logic unused_reps;
    assign unused_reps = ^bus.reps;
`endif

    always_comb begin
        nstate = state;
        cnt_n  = '0;
        done_n = 1'b0;
`ifdef HOLD_SEQ_REPEAT_EN
        rep_n  = rep_q;
`endif
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    // A zero length skips RUN entirely.
                    nstate = (bus.run_len != '0) ? S_RUN : S_LAST;
`ifdef HOLD_SEQ_REPEAT_EN
                    rep_n  = bus.reps;
`endif
                end
            end
            S_RUN: begin
                if ((cnt_q == len_q) || bus.abort) begin
                    nstate = S_LAST;
                end
            end
            S_LAST: begin
`ifdef HOLD_SEQ_REPEAT_EN
                if (rep_q != '0) begin
                    rep_n  = rep_q - 1'b1;
                    nstate = (len_q != '0) ? S_RUN : S_LAST;
                end else begin
                    nstate = S_IDLE;
                end
`else
                nstate = S_IDLE;
`endif
            end
            default: nstate = S_IDLE;
        endcase

        if (nstate == S_RUN) begin
            cnt_n = (state == S_RUN) ? cnt_q + CNT_W'(1) : CNT_W'(1);
        end

        // A LAST is final when no passes remain after this edge.
`ifdef HOLD_SEQ_REPEAT_EN
        done_n = (nstate == S_LAST) && (rep_n == '0);
`else
        done_n = (nstate == S_LAST);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            len_q  <= '0;
            cnt_q  <= '0;
            g_q    <= 1'b0;
            f_q    <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= nstate;
            if (accept) begin
                len_q <= bus.run_len;
            end
            cnt_q  <= cnt_n;
            g_q    <= (nstate != S_IDLE);
            busy_q <= (nstate != S_IDLE);
            done_q <= done_n;
            // LAST->LAST (zero-length repeat) is a fresh entry and toggles too.
            f_q    <= f_q ^ (nstate == S_LAST);
        end
    end

`ifdef HOLD_SEQ_REPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_q <= '0;
        end else begin
            rep_q <= rep_n;
        end
    end
`endif

    assign bus.g    = g_q;
    assign bus.f    = f_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.cnt  = cnt_q;

endmodule

// File: tb/tb_hold_seq_n.sv
// tb/tb_hold_seq_n.sv - self-checking bench for hold_seq_n

module tb_hold_seq_n;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    hold_seq_n_if #(.CNT_W(8), .REP_W(4)) bus ();

    hold_seq_n #(.CNT_W(8), .REP_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit run;
        int cnt;
        int pass;
        bit done;
    } ent_t;

    ent_t q[$];
    bit   f_exp = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   g_cnt, done_cnt, f_tog;
    logic f_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: a start expands into the list of per-cycle states it will produce.
    task automatic build();
        int passes;
        int len;
        len = int'(bus.run_len);
`ifdef HOLD_SEQ_REPEAT_EN
        passes = int'(bus.reps) + 1;
`else
        passes = 1;
`endif
        for (int p = 0; p < passes; p++) begin
            for (int k = 1; k <= len; k++) q.push_back('{1'b1, k, p, 1'b0});
            q.push_back('{1'b0, 0, p, (p == passes - 1)});
        end
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            q.delete();
            f_exp = 1'b0;
            return;
        end
        if (q.size() == 0) begin
            if (bus.start) begin
                build();
                if (!q[0].run) f_exp = ~f_exp;
            end
        end else begin
            if (q[0].run && bus.abort) begin
                while (q.size() > 1 && q[1].run && q[1].pass == q[0].pass) q.delete(1);
            end
            q.delete(0);
            if (q.size() > 0 && !q[0].run) f_exp = ~f_exp;
        end
    endtask

    task automatic check_outputs();
        bit active;
        active = (q.size() > 0);
        chk("g",    32'(bus.g),    32'(active));
        chk("busy", 32'(bus.busy), 32'(active));
        chk("f",    32'(bus.f),    32'(f_exp));
        chk("done", 32'(bus.done), active ? 32'(q[0].done) : 32'd0);
        chk("cnt",  32'(bus.cnt),  active ? 32'(q[0].cnt) : 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
        if (bus.g) g_cnt++;
        if (bus.done) done_cnt++;
        if (bus.f !== f_prev) f_tog++;
        f_prev = bus.f;
    endtask

    task automatic clr_counts();
        g_cnt = 0;
        done_cnt = 0;
        f_tog = 0;
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.run_len = '0;
        bus.abort   = 1'b0;
        bus.reps    = '0;

        // Reset state
        repeat (2) step();

        // 1: run_len=5, start accepted on first edge after reset release
        rst_n = 1'b1;
        clr_counts();
        bus.start = 1'b1;
        bus.run_len = 8'd5;
        step();
        bus.start = 1'b0;
        bus.run_len = 8'd0;
        repeat (9) step();
        chk("t1_g_cycles", 32'(g_cnt), 32'd6);
        chk("t1_done", 32'(done_cnt), 32'd1);
        chk("t1_f_toggles", 32'(f_tog), 32'd1);

        // 2: zero length
        clr_counts();
        bus.start = 1'b1;
        bus.run_len = 8'd0;
        step();
        bus.start = 1'b0;
        repeat (3) step();
        chk("t2_g_cycles", 32'(g_cnt), 32'd1);
        chk("t2_done", 32'(done_cnt), 32'd1);
        chk("t2_f_toggles", 32'(f_tog), 32'd1);

        // 3: abort at cnt=3 of run_len=10; abort+start together in IDLE accepts start
        clr_counts();
        bus.start = 1'b1;
        bus.abort = 1'b1;
        bus.run_len = 8'd10;
        step();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        for (int i = 0; i < 20 && bus.cnt != 8'd3; i++) step();
        chk("t3_reach_cnt3", 32'(bus.cnt), 32'd3);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        repeat (3) step();
        chk("t3_g_cycles", 32'(g_cnt), 32'd4);
        chk("t3_done", 32'(done_cnt), 32'd1);

        // 4: start held for 20 cycles, run_len=2 -> period of 4 cycles
        clr_counts();
        bus.start = 1'b1;
        bus.run_len = 8'd2;
        repeat (20) step();
        bus.start = 1'b0;
        repeat (4) step();
        chk("t4_done", 32'(done_cnt), 32'd5);
        chk("t4_g_cycles", 32'(g_cnt), 32'd15);

        // 5: reset mid-sequence at cnt=4 of run_len=8
        bus.start = 1'b1;
        bus.run_len = 8'd8;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 20 && bus.cnt != 8'd4; i++) step();
        chk("t5_reach_cnt4", 32'(bus.cnt), 32'd4);
        rst_n = 1'b0;
        #1;
        q.delete();
        f_exp = 1'b0;
        check_outputs();
        repeat (2) step();
        rst_n = 1'b1;
        clr_counts();
        bus.start = 1'b1;
        bus.run_len = 8'd3;
        step();
        bus.start = 1'b0;
        repeat (5) step();
        chk("t5_restart_g", 32'(g_cnt), 32'd4);
        chk("t5_restart_done", 32'(done_cnt), 32'd1);

`ifdef HOLD_SEQ_REPEAT_EN
        // 6: run_len=3, reps=2 -> three passes
        clr_counts();
        bus.start = 1'b1;
        bus.run_len = 8'd3;
        bus.reps = 4'd2;
        step();
        bus.start = 1'b0;
        bus.reps = 4'd0;
        repeat (14) step();
        chk("t6_g_cycles", 32'(g_cnt), 32'd12);
        chk("t6_done", 32'(done_cnt), 32'd1);
        chk("t6_f_toggles", 32'(f_tog), 32'd3);
`endif

        // Randomised traffic against the reference
        for (int i = 0; i < 400; i++) begin
            bus.start   = ($urandom_range(0, 2) == 0);
            bus.run_len = 8'($urandom_range(0, 6));
            bus.reps    = 4'($urandom_range(0, 3));
            bus.abort   = ($urandom_range(0, 5) == 0);
            step();
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        repeat (40) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
